// File: rtl/ubvcska_acc24.sv
// Streaming 24-bit framed accumulator built on a variable-block-size carry-skip adder.
// Each frame yields {carry_cnt, acc}, a saturating beat count and a sticky overflow flag.

module ubvcska_skip_blk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0]   c_s;
  logic [N-1:0] p_s;

  // Ripple inside the block; the block carry bypasses the ripple when every bit propagates.
  always_comb begin
    c_s    = {(N+1){1'b0}};
    p_s    = {N{1'b0}};
    s      = {N{1'b0}};
    c_s[0] = cin;
    for (int i = 0; i < N; i++) begin
      p_s[i]   = a[i] ^ b[i];
      s[i]     = p_s[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (p_s[i] & c_s[i]);
    end
    if (&p_s) begin
      cout = cin;
    end else begin
      cout = c_s[N];
    end
  end
endmodule

module UBVCSkA_23_0_23_0 (
  input  logic [23:0] X,
  input  logic [23:0] Y,
  output logic [24:0] S
);
  // Block sizes 2-3-4-6-4-3-2: short end blocks, long middle block to balance the skip path.
  logic c1_s, c2_s, c3_s, c4_s, c5_s, c6_s, c7_s;

  ubvcska_skip_blk #(.N(2)) u_b0 (.a(X[1:0]),   .b(Y[1:0]),   .cin(1'b0), .s(S[1:0]),   .cout(c1_s));
  ubvcska_skip_blk #(.N(3)) u_b1 (.a(X[4:2]),   .b(Y[4:2]),   .cin(c1_s), .s(S[4:2]),   .cout(c2_s));
  ubvcska_skip_blk #(.N(4)) u_b2 (.a(X[8:5]),   .b(Y[8:5]),   .cin(c2_s), .s(S[8:5]),   .cout(c3_s));
  ubvcska_skip_blk #(.N(6)) u_b3 (.a(X[14:9]),  .b(Y[14:9]),  .cin(c3_s), .s(S[14:9]),  .cout(c4_s));
  ubvcska_skip_blk #(.N(4)) u_b4 (.a(X[18:15]), .b(Y[18:15]), .cin(c4_s), .s(S[18:15]), .cout(c5_s));
  ubvcska_skip_blk #(.N(3)) u_b5 (.a(X[21:19]), .b(Y[21:19]), .cin(c5_s), .s(S[21:19]), .cout(c6_s));
  ubvcska_skip_blk #(.N(2)) u_b6 (.a(X[23:22]), .b(Y[23:22]), .cin(c6_s), .s(S[23:22]), .cout(c7_s));

  assign S[24] = c7_s;
endmodule

module ubvcska_acc24 #(
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic [8:0]  out_beats,
  output logic        out_ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [23:0] acc_r;
  logic [7:0]  carry_cnt_r;
  logic [8:0]  beats_r;
  logic        ovf_r;

  logic [23:0] add_x_s;
  logic [24:0] add_s;
  logic        accept_s;
  logic        xfer_s;

  assign accept_s = in_valid & in_ready_r;
  assign xfer_s   = out_valid_r & out_ready;

  // Adder X operand: zero outside ACC so a frame's first beat loads cleanly.
  always_comb begin
    if (state_r == ACC) begin
      add_x_s = acc_r;
    end else begin
      add_x_s = 24'd0;
    end
  end

  UBVCSkA_23_0_23_0 u_add (
    .X(add_x_s),
    .Y(in_data),
    .S(add_s)
  );

  // Frame FSM plus accumulator, carry count, beat count and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      acc_r       <= 24'd0;
      carry_cnt_r <= 8'd0;
      beats_r     <= 9'd0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r       <= add_s[23:0];
            carry_cnt_r <= 8'd0;
            beats_r     <= 9'd1;
            ovf_r       <= 1'b0;
            state_r     <= in_last ? DONE : ACC;
            in_ready_r  <= ~in_last;
            out_valid_r <= in_last;
          end else begin
            state_r <= IDLE;
          end
        end
        ACC: begin
          if (accept_s) begin
            acc_r <= add_s[23:0];
            if (add_s[24]) begin
              carry_cnt_r <= carry_cnt_r + 8'd1;
              if (carry_cnt_r == 8'd255) begin
                ovf_r <= 1'b1;
              end else begin
                ovf_r <= ovf_r;
              end
            end else begin
              carry_cnt_r <= carry_cnt_r;
            end
            if (beats_r != 9'd511) begin
              beats_r <= beats_r + 9'd1;
            end else begin
              beats_r <= beats_r;
            end
            state_r     <= in_last ? DONE : ACC;
            in_ready_r  <= ~in_last;
            out_valid_r <= in_last;
          end else begin
            state_r <= ACC;
          end
        end
        DONE: begin
          if (xfer_s) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = {carry_cnt_r, acc_r};
  assign out_beats = beats_r;
  assign out_ovf   = ovf_r;
endmodule

// File: tb/tb_ubvcska_acc24.sv
// Directed bench for ubvcska_acc24: a table of frames plus hand-written
// backpressure, gap and reset sequences.

module tb_ubvcska_acc24;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [8:0]  out_beats;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  ubvcska_acc24 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] first;
    logic [23:0] rest;
    int          n;
    logic [31:0] exp_sum;
    logic [8:0]  exp_beats;
    logic        exp_ovf;
  } frame_t;

  frame_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one beat starting at a negedge; returns after the posedge that accepts it.
  task automatic beat(input logic [23:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 20; k++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready stuck at %b, expected 1", in_ready);
    end
  endtask

  task automatic idle_input();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [31:0] s, input logic [8:0] b, input logic o);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({name, "_sum"}, out_sum, s);
    check({name, "_beats"}, {23'd0, out_beats}, {23'd0, b});
    check({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_out_sum"}, out_sum, 32'd0);
    check({name, "_out_beats"}, {23'd0, out_beats}, 32'd0);
    check({name, "_out_ovf"}, {31'd0, out_ovf}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation ran past limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"single",   24'h123456, 24'h000000,   1, 32'h00123456, 9'd1,   1'b0};
    vecs[1] = '{"carry",    24'hFFFFFF, 24'h000001,   2, 32'h01000000, 9'd2,   1'b0};
    vecs[2] = '{"full256",  24'hFFFFFF, 24'hFFFFFF, 256, 32'hFFFFFF00, 9'd256, 1'b0};
    vecs[3] = '{"ovf257",   24'hFFFFFF, 24'hFFFFFF, 257, 32'h00FFFEFF, 9'd257, 1'b1};
    vecs[4] = '{"three",    24'h000001, 24'h800000,   3, 32'h01000001, 9'd3,   1'b0};
    vecs[5] = '{"sat600",   24'h000001, 24'h000001, 600, 32'h00000258, 9'd511, 1'b0};
    vecs[6] = '{"zero",     24'h000000, 24'h000000,   1, 32'h00000000, 9'd1,   1'b0};
    vecs[7] = '{"maxone",   24'hFFFFFF, 24'h000000,   1, 32'h00FFFFFF, 9'd1,   1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 24'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        beat((i == 0) ? vecs[v].first : vecs[v].rest, (i == vecs[v].n - 1));
      end
      idle_input();
      check_result(vecs[v].name, vecs[v].exp_sum, vecs[v].exp_beats, vecs[v].exp_ovf);
      @(negedge clk);
      check({vecs[v].name, "_after_xfer_valid"}, {31'd0, out_valid}, 32'd0);
      check({vecs[v].name, "_after_xfer_ready"}, {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held while next beat waits.
    out_ready = 1'b0;
    beat(24'h000005, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'h000009;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_result("bp_hold", 32'h00000005, 9'd1, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
    check("bp_xfer_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp_next", 32'h00000009, 9'd1, 1'b0);
    @(negedge clk);

    // Gapped frame.
    beat(24'h000010, 1'b0);
    idle_input();
    for (int g = 0; g < 3; g++) begin
      check("gap_ready", {31'd0, in_ready}, 32'd1);
      check("gap_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    beat(24'h000020, 1'b1);
    idle_input();
    check_result("gap", 32'h00000030, 9'd2, 1'b0);
    @(negedge clk);

    // Mid-frame reset.
    beat(24'h000001, 1'b0);
    beat(24'h000002, 1'b0);
    beat(24'h000003, 1'b0);
    idle_input();
    check("pre_reset_sum", out_sum, 32'h00000006);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    beat(24'h000007, 1'b1);
    idle_input();
    check_result("post_reset", 32'h00000007, 9'd1, 1'b0);

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("done_reset");
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
